gpout_probe: RTL



---
 rtl/gpout_probe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/gpout_probe.sv
// -----------------------------------------------------------------------------
// gpout_probe
//   Routes any of NSRC internal debug sources to each of NCH general-purpose
//   output pins. Every channel has its own conditioning mode so that short or
//   fast events stay visible on a scope or logic analyser. One shared
//   programmable clock divider is also provided.
//
// Ports
//   clk        : sole clock
//   reset      : synchronous, active-high reset
//   i_src      : flattened source vector, bit k is source k
//   i_sel      : per-channel source select, channel c uses [c*SELW +: SELW]
//   i_mode     : per-channel mode, channel c uses [c*2 +: 2]
//                0 = direct, 1 = registered, 2 = pulse-stretch, 3 = edge-toggle
//   i_div      : divider setting N
//   o_gpout    : conditioned channel outputs
//   o_div_clk  : clk divided by 2*(N+1), registered
// -----------------------------------------------------------------------------
module gpout_probe #(
   parameter int unsigned NCH     = 6,
   parameter int unsigned NSRC    = 64,
   parameter int unsigned SELW    = 6,
   parameter int unsigned STRETCH = 15,
   parameter int unsigned DIVW    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC-1:0]      i_src,
   input  logic [NCH*SELW-1:0]  i_sel,
   input  logic [NCH*2-1:0]     i_mode,
   input  logic [DIVW-1:0]      i_div,
   output logic [NCH-1:0]       o_gpout,
   output logic                 o_div_clk
);

   localparam int unsigned NPAD = 2**SELW;
   localparam int unsigned CNTW = $clog2(STRETCH + 1);

   localparam logic [1:0] MODE_DIRECT  = 2'd0;
   localparam logic [1:0] MODE_REG     = 2'd1;
   localparam logic [1:0] MODE_STRETCH = 2'd2;
   localparam logic [1:0] MODE_TOGGLE  = 2'd3;

   // Zero-padding the source vector to the full select range makes any
   // select at or above NSRC read back as 0 without a separate compare.
   logic [NPAD-1:0] src_pad;
   assign src_pad = NPAD'(i_src);

   // Edge detection is suppressed on the first cycle out of reset.
   logic vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= 1'b0;
      end else begin
         vld <= 1'b1;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [SELW-1:0] sel;
      logic [1:0]      mode;
      logic            s;
      logic            r_s;
      logic            prev;
      logic            tog;
      logic [CNTW-1:0] cnt;
      logic [SELW-1:0] last_sel;
      logic [1:0]      last_mode;
      logic            cfg_chg;
      logic            rise;
      logic            gp;

      assign sel  = i_sel[c*SELW +: SELW];
      assign mode = i_mode[c*2 +: 2];
      assign s    = src_pad[sel];

      // A reconfiguration cycle never counts as an edge, so switching onto a
      // source that is already high does not fire a stretch or toggle.
      assign cfg_chg = (sel != last_sel) || (mode != last_mode);
      assign rise    = vld && !cfg_chg && s && !prev;

      // Conditioning state; runs in every mode so a mode switch starts clean.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_s       <= 1'b0;
            prev      <= 1'b0;
            tog       <= 1'b0;
            cnt       <= '0;
            last_sel  <= '0;
            last_mode <= '0;
         end else begin
            r_s       <= s;
            prev      <= s;
            last_sel  <= sel;
            last_mode <= mode;
            if (cfg_chg) begin
               cnt <= '0;
               tog <= 1'b0;
            end else begin
               if (rise) begin
                  cnt <= CNTW'(STRETCH);
               end else if (cnt != '0) begin
                  cnt <= cnt - CNTW'(1);
               end
               if (rise) begin
                  tog <= ~tog;
               end
            end
         end
      end

      // Output select; direct mode is a pure combinational path.
      always_comb begin
         gp = 1'b0;
         case (mode)
            MODE_DIRECT:  gp = s;
            MODE_REG:     gp = r_s;
            MODE_STRETCH: gp = (cnt != '0);
            MODE_TOGGLE:  gp = tog;
            default:      gp = 1'b0;
         endcase
      end

      assign o_gpout[c] = gp;
   end

   // Shared divider; the >= compare lets a lowered setting wrap immediately.
   logic [DIVW-1:0] dcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         dcnt      <= '0;
         o_div_clk <= 1'b0;
      end else if (dcnt >= i_div) begin
         dcnt      <= '0;
         o_div_clk <= ~o_div_clk;
      end else begin
         dcnt      <= dcnt + DIVW'(1);
      end
   end

endmodule
